// File: rtl/wired_bpu_feedback.sv
// Fetch-target queue between the branch predictor and fetch. Resolved branches are checked
// against the stored prediction and turned into one registered correction per resolution.
module wired_bpu_feedback #(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned IDW = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           p_valid_i,
  output logic           p_ready_o,
  input  logic [31:0]    p_pc_i,
  input  logic [1:0]     p_mask_i,
  input  logic [15:0]    p_predict_i,
  output logic [108:0]   p_correct_o,
  output logic           f_valid_o,
  input  logic           f_ready_i,
  output logic [31:0]    f_pc_o,
  output logic [1:0]     f_mask_o,
  output logic [IDW-1:0] f_id_o,
  input  logic           r_valid_i,
  output logic           r_ready_o,
  input  logic [IDW-1:0] r_id_i,
  input  logic           r_slot_i,
  input  logic           r_taken_i,
  input  logic           r_conditional_i,
  input  logic [1:0]     r_target_type_i,
  input  logic [31:0]    r_target_i,
  input  logic           c_valid_i
);

  // Flattened onto p_correct_o MSB-first; each predict slot is {taken, history[4:0], lphr[1:0]}.
  typedef struct packed {
    logic        need_update;
    logic        redirect;
    logic [31:0] pc;
    logic        true_taken;
    logic [31:0] true_target;
    logic [31:0] btb_target;
    logic [1:0]  true_target_type;
    logic        true_conditional_jmp;
    logic [4:0]  history;
    logic [1:0]  lphr;
  } correct_t;

  localparam logic [IDW:0] PtrOne = 1;

  logic [IDW:0]     r_head, r_fetch, r_tail;
  logic [28:0]      r_pc     [DEPTH];
  logic [1:0]       r_mask   [DEPTH];
  logic [15:0]      r_pred   [DEPTH];
  logic [28:0]      r_nxt_pc [DEPTH];
  logic [DEPTH-1:0] r_nxt_v;
  correct_t         r_corr;

  logic           w_empty, w_full, w_enq, w_fire, w_commit;
  logic [IDW-1:0] w_tid, w_tid_prev, w_fid, w_rid_off;
  logic [7:0]     w_rpred;
  logic           w_pt, w_res, w_mp, w_trim, w_fetch_clamp;
  logic [31:0]    w_spc;
  logic [IDW:0]   w_rid_ptr, w_new_tail, w_fetch_nxt;
  correct_t       w_corr;
  logic           w_unused_pc;

  assign w_unused_pc = ^p_pc_i[2:0];

  assign w_empty    = (r_head == r_tail);
  assign w_full     = (r_head[IDW-1:0] == r_tail[IDW-1:0]) && (r_head[IDW] != r_tail[IDW]);
  assign p_ready_o  = !w_full || r_corr.redirect;
  assign w_enq      = p_valid_i && p_ready_o && !r_corr.redirect;
  assign w_tid      = r_tail[IDW-1:0];
  assign w_tid_prev = w_tid - 1'b1;

  assign w_fid     = r_fetch[IDW-1:0];
  assign f_valid_o = (r_fetch != r_tail);
  assign f_pc_o    = {r_pc[w_fid], 3'b000};
  assign f_mask_o  = r_mask[w_fid];
  assign f_id_o    = w_fid;
  assign w_fire    = f_valid_o && f_ready_i;
  assign w_commit  = c_valid_i && !w_empty;

  assign w_rpred   = r_slot_i ? r_pred[r_id_i][15:8] : r_pred[r_id_i][7:0];
  assign w_pt      = w_rpred[7];
  // A predicted-taken branch can only be checked once its successor packet exists.
  assign r_ready_o = !(w_pt && !r_nxt_v[r_id_i]);
  assign w_res     = r_valid_i && r_ready_o;
  assign w_spc     = {r_pc[r_id_i], r_slot_i, 2'b00};
  assign w_mp      = (w_pt != r_taken_i)
                  || (w_pt && r_taken_i && ({r_nxt_pc[r_id_i], 3'b000} != r_target_i))
                  || (r_taken_i && (r_target_i[2:0] != 3'b000));
  assign w_trim    = w_res && w_mp;

  // Rebuild the wrap bit of the resolved entry from its distance to head.
  assign w_rid_off     = r_id_i - r_head[IDW-1:0];
  assign w_rid_ptr     = r_head + {1'b0, w_rid_off};
  assign w_new_tail    = w_rid_ptr + PtrOne;
  assign w_fetch_nxt   = w_fire ? (r_fetch + PtrOne) : r_fetch;
  assign w_fetch_clamp = (w_fetch_nxt - r_head) > (w_new_tail - r_head);

  always_comb begin
    w_corr = '0;
    if (w_res) begin
      w_corr.need_update          = 1'b1;
      w_corr.redirect             = w_mp;
      w_corr.pc                   = w_spc;
      w_corr.true_taken           = r_taken_i;
      w_corr.true_target          = r_taken_i ? r_target_i : (w_spc + 32'd4);
      w_corr.btb_target           = r_target_i;
      w_corr.true_target_type     = r_target_type_i;
      w_corr.true_conditional_jmp = r_conditional_i;
      w_corr.history              = w_rpred[6:2];
      w_corr.lphr                 = w_rpred[1:0];
    end
  end

  assign p_correct_o = r_corr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_fetch <= '0;
      r_tail  <= '0;
      r_nxt_v <= '0;
      r_corr  <= '0;
    end else begin
      if (w_commit) r_head <= r_head + PtrOne;
      if (w_trim) begin
        r_tail          <= w_new_tail;
        r_fetch         <= w_fetch_clamp ? w_new_tail : w_fetch_nxt;
        r_nxt_v[r_id_i] <= 1'b0;
      end else begin
        r_fetch <= w_fetch_nxt;
        if (w_enq) begin
          r_tail         <= r_tail + PtrOne;
          r_nxt_v[w_tid] <= 1'b0;
          if (!w_empty) r_nxt_v[w_tid_prev] <= 1'b1;
        end
      end
      r_corr <= w_corr;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq && !w_trim) begin
      r_pc[w_tid]   <= p_pc_i[31:3];
      r_mask[w_tid] <= p_mask_i;
      r_pred[w_tid] <= p_predict_i;
      if (!w_empty) r_nxt_pc[w_tid_prev] <= p_pc_i[31:3];
    end
  end

endmodule

// File: tb/tb_wired_bpu_feedback.sv
// Randomized and directed checks of wired_bpu_feedback against a queue-level reference model.
module tb_wired_bpu_feedback;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic        need_update;
    logic        redirect;
    logic [31:0] pc;
    logic        true_taken;
    logic [31:0] true_target;
    logic [31:0] btb_target;
    logic [1:0]  true_target_type;
    logic        true_conditional_jmp;
    logic [4:0]  history;
    logic [1:0]  lphr;
  } corr_t;

  typedef struct {
    logic [28:0] pc;
    logic [1:0]  mask;
    logic [15:0] pred;
    int          seq;
  } ent_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic p_valid, f_ready, r_valid, r_slot, r_taken, r_cond, c_valid;
  logic [31:0] p_pc, r_target;
  logic [1:0] p_mask, r_ttype;
  logic [15:0] p_pred;
  logic [2:0] r_id;
  logic p_ready_o, f_valid_o, r_ready_o;
  logic [108:0] p_correct_o;
  logic [31:0] f_pc_o;
  logic [1:0] f_mask_o;
  logic [2:0] f_id_o;

  ent_t mq[$];
  int fcnt, seq_ctr, res_next, r_seq;
  logic res_pend;
  corr_t m_corr, c;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  wired_bpu_feedback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_valid_i(p_valid), .p_ready_o(p_ready_o), .p_pc_i(p_pc), .p_mask_i(p_mask),
    .p_predict_i(p_pred), .p_correct_o(p_correct_o),
    .f_valid_o(f_valid_o), .f_ready_i(f_ready), .f_pc_o(f_pc_o), .f_mask_o(f_mask_o),
    .f_id_o(f_id_o),
    .r_valid_i(r_valid), .r_ready_o(r_ready_o), .r_id_i(r_id), .r_slot_i(r_slot),
    .r_taken_i(r_taken), .r_conditional_i(r_cond), .r_target_type_i(r_ttype),
    .r_target_i(r_target), .c_valid_i(c_valid)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    p_valid = 0; p_pc = '0; p_mask = '0; p_pred = '0; f_ready = 0;
    r_valid = 0; r_id = '0; r_slot = 0; r_taken = 0; r_cond = 0; r_ttype = '0;
    r_target = '0; c_valid = 0; r_seq = -1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    mq.delete(); fcnt = 0; seq_ctr = 0; res_next = 0; res_pend = 0; m_corr = '0;
  endtask

  // Check all outputs against the model, then advance model and DUT by one clock.
  task automatic step();
    int ri;
    logic pt, hasn, mp, acc, enq, fire, com, exp_pr, exp_fv, exp_rr;
    logic [7:0] pb;
    logic [31:0] spc, nxt;
    corr_t nc;
    ent_t ne;
    @(negedge clk);
    exp_pr = (mq.size() < DEPTH) || m_corr.redirect;
    exp_fv = fcnt < mq.size();
    check_eq("p_ready", p_ready_o, exp_pr);
    check_eq("f_valid", f_valid_o, exp_fv);
    if (exp_fv) begin
      check_eq("f_pc", f_pc_o, {mq[fcnt].pc, 3'b000});
      check_eq("f_mask", f_mask_o, mq[fcnt].mask);
      check_eq("f_id", f_id_o, mq[fcnt].seq % DEPTH);
    end
    check_eq("p_correct", p_correct_o, m_corr);
    ri = -1;
    foreach (mq[i]) if (mq[i].seq == r_seq) ri = i;
    acc = 0; mp = 0; nc = '0;
    if (r_valid && ri >= 0) begin
      pb = r_slot ? mq[ri].pred[15:8] : mq[ri].pred[7:0];
      pt = pb[7];
      hasn = (ri + 1) < mq.size();
      nxt = hasn ? {mq[ri+1].pc, 3'b000} : 32'h0;
      exp_rr = !(pt && !hasn);
      check_eq("r_ready", r_ready_o, exp_rr);
      acc = exp_rr;
      spc = {mq[ri].pc, r_slot, 2'b00};
      mp = (pt != r_taken) || (pt && r_taken && nxt != r_target)
        || (r_taken && r_target[2:0] != 3'b000);
      if (acc) begin
        nc.need_update = 1; nc.redirect = mp; nc.pc = spc; nc.true_taken = r_taken;
        nc.true_target = r_taken ? r_target : spc + 4; nc.btb_target = r_target;
        nc.true_target_type = r_ttype; nc.true_conditional_jmp = r_cond;
        nc.history = pb[6:2]; nc.lphr = pb[1:0];
      end
    end
    enq = p_valid && exp_pr && !m_corr.redirect;
    fire = exp_fv && f_ready;
    com = c_valid && mq.size() > 0;
    if (fire) fcnt++;
    if (acc && mp) begin
      while (mq.size() > ri + 1) void'(mq.pop_back());
      if (fcnt > ri + 1) fcnt = ri + 1;
      seq_ctr = mq[ri].seq + 1;
    end else if (enq) begin
      ne.pc = p_pc[31:3]; ne.mask = p_mask; ne.pred = p_pred; ne.seq = seq_ctr;
      seq_ctr++;
      mq.push_back(ne);
    end
    if (com) begin
      void'(mq.pop_front());
      if (fcnt > 0) fcnt--;
    end
    m_corr = nc;
    if (acc) begin
      res_next = r_seq + 1;
      res_pend = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [15:0] pred);
    p_valid = 1; p_pc = pc; p_mask = 2'b11; p_pred = pred;
    step();
    p_valid = 0;
  endtask

  task automatic resolve(input int seq, input logic slot, input logic taken,
                         input logic [31:0] tgt);
    r_valid = 1; r_seq = seq; r_id = 3'(seq % DEPTH); r_slot = slot; r_taken = taken;
    r_cond = 1; r_ttype = 2'd1; r_target = tgt;
  endtask

  task automatic fetch_n(input int n);
    f_ready = 1;
    repeat (n) step();
    f_ready = 0;
  endtask

  task automatic setup_taken_pair();
    push(32'h1c000000, 16'h0000);
    push(32'h1c000008, 16'h0000);
    push(32'h1c000018, 16'h8a00);
    push(32'h1c000100, 16'h0000);
    fetch_n(4);
  endtask

  function automatic logic [7:0] rand_pred();
    return {($urandom_range(3) == 0), 5'($urandom), 2'($urandom)};
  endfunction

  task automatic gen_inputs();
    int cand[$];
    int k, pick;
    p_valid = ($urandom_range(3) != 0);
    p_pc = $urandom; p_mask = 2'($urandom); p_pred = {rand_pred(), rand_pred()};
    f_ready = ($urandom_range(2) != 0);
    if (mq.size() == 0) c_valid = ($urandom_range(3) == 0);
    else c_valid = (fcnt > 0) && (mq[0].seq < res_next) && ($urandom_range(2) == 0);
    if (!res_pend) begin
      r_valid = 0;
      for (int i = 0; i < fcnt; i++) if (mq[i].seq >= res_next) cand.push_back(i);
      if (cand.size() > 0 && $urandom_range(1) == 1) begin
        pick = cand[$urandom_range(cand.size() - 1)];
        resolve(mq[pick].seq, 1'($urandom), 1'($urandom), {$urandom, 3'b000} >> 3 << 3);
        r_cond = 1'($urandom); r_ttype = 2'($urandom);
        k = $urandom_range(3);
        if (k == 1) r_target = $urandom;
        else if (k >= 2 && pick + 1 < mq.size()) r_target = {mq[pick+1].pc, 3'b000};
        res_next = mq[pick].seq;
        res_pend = 1;
      end
    end
  endtask

  initial begin
    do_reset();
    check_eq("rst_p_ready", p_ready_o, 1'b1);
    check_eq("rst_f_valid", f_valid_o, 1'b0);
    check_eq("rst_p_correct", p_correct_o, 109'd0);

    // In-order packet delivery.
    push(32'h1c000000, 16'h0000);
    push(32'h1c000008, 16'h0000);
    push(32'h1c000010, 16'h0000);
    check_eq("seq_pc0", f_pc_o, 32'h1c000000);
    fetch_n(1);
    check_eq("seq_pc1", f_pc_o, 32'h1c000008);
    fetch_n(1);
    check_eq("seq_pc2", f_pc_o, 32'h1c000010);
    fetch_n(1);
    check_eq("seq_corr", p_correct_o, 109'd0);

    // Full queue back-pressure and release by commit.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push(32'h1c000000 + 32'(i * 8), 16'h0000);
    check_eq("full_ready", p_ready_o, 1'b0);
    fetch_n(1);
    check_eq("full_ready_fetch", p_ready_o, 1'b0);
    c_valid = 1; step(); c_valid = 0;
    check_eq("commit_ready", p_ready_o, 1'b1);

    // Correctly predicted taken branch.
    do_reset();
    setup_taken_pair();
    resolve(2, 1'b1, 1'b1, 32'h1c000100); step(); set_idle();
    c = p_correct_o;
    check_eq("hit_update", c.need_update, 1'b1);
    check_eq("hit_redirect", c.redirect, 1'b0);
    check_eq("hit_pc", c.pc, 32'h1c00001c);
    check_eq("hit_hist", {c.history, c.lphr}, 7'h0a);

    // Wrong target: redirect, trim, wrong-path packet dropped.
    do_reset();
    setup_taken_pair();
    resolve(2, 1'b1, 1'b1, 32'h1c000200); step(); set_idle();
    c = p_correct_o;
    check_eq("mp_redirect", c.redirect, 1'b1);
    check_eq("mp_target", c.true_target, 32'h1c000200);
    check_eq("mp_ready", p_ready_o, 1'b1);
    check_eq("mp_trim_fvalid", f_valid_o, 1'b0);
    push(32'h1c000300, 16'h0000);
    check_eq("mp_drop_fvalid", f_valid_o, 1'b0);
    check_eq("mp_pulse", p_correct_o, 109'd0);
    push(32'h1c000200, 16'h0000);
    check_eq("mp_new_id", f_id_o, 3'd3);
    check_eq("mp_new_pc", f_pc_o, 32'h1c000200);

    // Taken prediction on the youngest entry stalls resolution.
    do_reset();
    push(32'h1c000000, 16'h0080);
    fetch_n(1);
    resolve(0, 1'b0, 1'b1, 32'h1c000020);
    #1;
    check_eq("stall_rready", r_ready_o, 1'b0);
    step();
    push(32'h1c000020, 16'h0000);
    check_eq("stall_release", r_ready_o, 1'b1);
    step(); set_idle();
    c = p_correct_o;
    check_eq("stall_update", {c.need_update, c.redirect}, 2'b10);

    // Predicted taken, actually not taken.
    do_reset();
    push(32'h1c000040, 16'h0080);
    push(32'h1c000048, 16'h0000);
    fetch_n(2);
    resolve(0, 1'b0, 1'b0, 32'h1c000100); step(); set_idle();
    c = p_correct_o;
    check_eq("nt_redirect", c.redirect, 1'b1);
    check_eq("nt_target", c.true_target, 32'h1c000044);

    // Randomized traffic, with a reset in the middle.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      gen_inputs();
      step();
    end
    do_reset();
    check_eq("midrst_corr", p_correct_o, 109'd0);
    check_eq("midrst_fvalid", f_valid_o, 1'b0);
    check_eq("midrst_ready", p_ready_o, 1'b1);
    for (int n = 0; n < 2000; n++) begin
      gen_inputs();
      step();
    end
    set_idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
